tone_seq_player: RTL
====================

Name: tone_seq_player

Overview:
- Parametrised successor to the single-note square-wave generators: one block plays any of 12 chromatic notes over 4 octaves, or a rest, for a programmed duration in milliseconds.
- A valid/ready command interface accepts one note per command, and a done pulse signals completion, so a sequencer (song ROM walker) can queue notes.
- Sits between the sequencer/switch logic and the speaker pin.

Parameters:
- CLK_MHZ, 20, system clock in MHz; all cycle counts scale by it.
- CNT_W, 17, tone half-period counter width; must satisfy 2^CNT_W > CLK_MHZ*1911.
- PRE_W, 15, millisecond prescaler width; must satisfy 2^PRE_W > CLK_MHZ*1000.
- DUR_W, 16, duration field width in ms.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command.
- note  in  4  0..11 = C..B; 12..15 = rest.
- octave  in  2  0..3 = octave 4..7.
- dur_ms  in  DUR_W  note length in ms.
- enable  in  1  output gate (the board switch).
- speaker  out  1  square-wave output.
- busy  out  1  note in progress.
- done  out  1  one-cycle pulse at note end.

Behaviour:
- Reset: asynchronous, active-low. Clears state to IDLE, all counters, and the tone flop. While reset is asserted and after release: speaker=0, busy=0, done=0, in_ready=1.
- Half-period table, octave 4, in µs: C 1911, C# 1804, D 1703, D# 1607, E 1517, F 1432, F# 1351, G 1276, G# 1204, A 1136, A# 1073, B 1012.
- Limit: limit = (CLK_MHZ*table[note]) >> octave, truncated. Compute it once at accept and register it.
- States: IDLE and PLAY. in_ready = (state==IDLE). busy = (state==PLAY).
- Accept: a command is accepted on a rising edge with in_valid=1 and in_ready=1. On that edge:
  - latch limit, the rest flag and dur_ms;
  - clear the tone counter, ms prescaler and tone flop;
  - go to PLAY.
  - Exception: if dur_ms==0, stay in IDLE and pulse done for the next cycle. No tone is produced.
- Tone counter in PLAY: increments each cycle. When it equals limit-1, it clears and the tone flop toggles. Each output level therefore lasts exactly limit cycles.
- Rest: for notes 12..15, the tone flop is held at 0; the duration still runs.
- Duration: the prescaler counts 0..CLK_MHZ*1000-1 and wraps. Each wrap decrements the remaining-ms counter. When remaining reaches 0:
  - state returns to IDLE;
  - the tone flop clears;
  - done is high for exactly one cycle, the first IDLE cycle.
- Timing: done is registered high exactly dur_ms*CLK_MHZ*1000 cycles after the accept edge.
- Output: speaker = enable & tone & busy, driven by a registered tone flop. enable does not affect the counters or duration.
- Command timing: in_valid is ignored while busy. The earliest next accept is the edge at which done is high, giving back-to-back notes with no extra gap. A command presented in the same cycle that done is high is accepted.
- Command hold: note, octave and dur_ms need only be stable on the accept edge.
- Reset mid-note: speaker drops immediately (asynchronously). No done pulse is issued.

Test Plan (CLK_MHZ=1 override for simulation speed):
- Reset, then note=4 (E), octave=0, dur=3 accepted at t0 -> speaker toggles every 1517 cycles; busy high for 3000 cycles; done pulses once at t0+3000; in_ready rises at the same time.
- note=9 (A), octave=2, dur=1 -> limit 284; level changes every 284 cycles; done at t0+1000.
- note=12 (rest), dur=2 -> speaker stays 0 throughout; busy high for 2000 cycles; done at t0+2000.
- dur=0 with note=0 -> no PLAY; done high the cycle after accept; speaker stays 0.
- enable=0 during E4 note -> speaker 0, done still at t0+3000. Raise enable mid-note -> speaker resumes, phase-consistent with an ungated reference.
- Assert rst_n=0 at t0+1200 of a 3 ms note -> speaker, busy and done go 0 immediately. After release, in_ready=1; a new command plays normally.
- Second command held valid during the first note (C4, dur=1) -> accepted on the done edge; next note starts with zero idle cycles.

Source files
------------

// File: rtl/tone_seq_player.sv
// Chromatic square-wave note player: one note or rest per valid/ready command,
// played for a programmed number of milliseconds, with a done pulse at note end.
module tone_seq_player #(
    parameter int CLK_MHZ = 20,
    parameter int CNT_W   = 17,
    parameter int PRE_W   = 15,
    parameter int DUR_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       note,
    input  logic [1:0]       octave,
    input  logic [DUR_W-1:0] dur_ms,
    input  logic             enable,
    output logic             speaker,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_MHZ * 1000 - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   limit_q;
    logic [PRE_W-1:0]   pre_q;
    logic [DUR_W-1:0]   rem_q;
    logic               rest_q;
    logic               tone_q;
    logic               done_q;
    logic               accept;
    logic               ms_tick;
    logic               note_end;

    // Octave-4 half period in microseconds, scaled to cycles and shifted up by octave.
    function automatic logic [CNT_W-1:0] calc_limit(input logic [3:0] n, input logic [1:0] o);
        int hp;
        case (n)
            4'd0:    hp = 1911;
            4'd1:    hp = 1804;
            4'd2:    hp = 1703;
            4'd3:    hp = 1607;
            4'd4:    hp = 1517;
            4'd5:    hp = 1432;
            4'd6:    hp = 1351;
            4'd7:    hp = 1276;
            4'd8:    hp = 1204;
            4'd9:    hp = 1136;
            4'd10:   hp = 1073;
            4'd11:   hp = 1012;
            default: hp = 1;
        endcase
        return CNT_W'((CLK_MHZ * hp) >> o);
    endfunction

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == PLAY);
    assign done     = done_q;
    assign speaker  = enable & tone_q & busy;

    assign accept   = in_valid && (state_q == IDLE);
    assign ms_tick  = (pre_q == PRE_LAST);
    assign note_end = (state_q == PLAY) && ms_tick && (rem_q == DUR_W'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && (dur_ms != '0)) state_d = PLAY;
            PLAY: if (note_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (accept && (dur_ms == '0)) || note_end;
        end
    end

    // Note parameters are latched at accept; only the counters and tone flop need reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            limit_q <= calc_limit(note, octave);
            rest_q  <= (note >= 4'd12);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            rem_q  <= '0;
            tone_q <= 1'b0;
        end else if (accept) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            rem_q  <= dur_ms;
            tone_q <= 1'b0;
        end else if (state_q == PLAY) begin
            pre_q <= ms_tick ? '0 : pre_q + PRE_W'(1);
            if (ms_tick) rem_q <= rem_q - DUR_W'(1);
            if (note_end) begin
                cnt_q  <= '0;
                tone_q <= 1'b0;
            end else if (cnt_q == limit_q - CNT_W'(1)) begin
                cnt_q  <= '0;
                tone_q <= rest_q ? 1'b0 : ~tone_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
